vga_timing_gen: RTL and testbench

//  Raster timing generator for the display path. Produces pixel coordinates
//  gr_x/gr_y, the active-video qualifier `enable`, HSYNC/VSYNC and frame/line

---
 rtl/vga_timing_gen.sv | 132 +++++++++++++
 tb/tb_vga_timing_gen.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing generator producing pixel coordinates, the
// active-video qualifier, H/V sync and line/frame strobes. Every output is a
// register decoded from the next-state position, so all outputs in a given
// cycle describe the same (gr_x, gr_y).
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 800,
  parameter int unsigned H_FP     = 40,
  parameter int unsigned H_SYNC   = 128,
  parameter int unsigned H_BP     = 88,
  parameter int unsigned V_ACTIVE = 600,
  parameter int unsigned V_FP     = 1,
  parameter int unsigned V_SYNC   = 4,
  parameter int unsigned V_BP     = 23,
  parameter int unsigned HS_POL   = 1,
  parameter int unsigned VS_POL   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  output logic [10:0] gr_x,
  output logic [9:0]  gr_y,
  output logic        enable,
  output logic        hsync,
  output logic        vsync,
  output logic        line_start,
  output logic        frame_start,
  output logic [15:0] frame_cnt
);

  localparam int unsigned XW = 11;
  localparam int unsigned YW = 10;
  localparam int unsigned FW = 16;

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [XW-1:0] H_LAST   = XW'(H_TOTAL - 1);
  localparam logic [YW-1:0] V_LAST   = YW'(V_TOTAL - 1);
  localparam logic [XW-1:0] H_ACT    = XW'(H_ACTIVE);
  localparam logic [YW-1:0] V_ACT    = YW'(V_ACTIVE);
  localparam logic [XW-1:0] HS_START = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0] HS_END   = XW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [YW-1:0] VS_START = YW'(V_ACTIVE + V_FP);
  localparam logic [YW-1:0] VS_END   = YW'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic HS_ON = 1'(HS_POL);
  localparam logic VS_ON = 1'(VS_POL);

  // started_q is low between reset and the first run edge, so that edge
  // presents (0,0) with its strobes rather than stepping past it.
  logic          started_q,     started_d;
  logic [XW-1:0] x_q,           x_d;
  logic [YW-1:0] y_q,           y_d;
  logic          enable_q,      enable_d;
  logic          hsync_q,       hsync_d;
  logic          vsync_q,       vsync_d;
  logic          line_start_q,  line_start_d;
  logic          frame_start_q, frame_start_d;
  logic [FW-1:0] frame_cnt_q,   frame_cnt_d;

  // Next position and output decode; everything holds while run is low.
  always_comb begin
    started_d     = started_q;
    x_d           = x_q;
    y_d           = y_q;
    frame_cnt_d   = frame_cnt_q;
    enable_d      = enable_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    line_start_d  = line_start_q;
    frame_start_d = frame_start_q;

    if (run) begin
      if (!started_q) begin
        started_d = 1'b1;
        x_d       = '0;
        y_d       = '0;
      end else if (x_q == H_LAST) begin
        x_d = '0;
        if (y_q == V_LAST) begin
          y_d         = '0;
          frame_cnt_d = frame_cnt_q + FW'(1);
        end else begin
          y_d = y_q + YW'(1);
        end
      end else begin
        x_d = x_q + XW'(1);
      end

      enable_d      = (x_d < H_ACT) && (y_d < V_ACT);
      hsync_d       = ((x_d >= HS_START) && (x_d < HS_END)) ? HS_ON : ~HS_ON;
      vsync_d       = ((y_d >= VS_START) && (y_d < VS_END)) ? VS_ON : ~VS_ON;
      line_start_d  = (x_d == '0);
      frame_start_d = (x_d == '0) && (y_d == '0);
    end
  end

  // State and output registers with synchronous reset taking priority over run.
  always_ff @(posedge clk) begin
    if (reset) begin
      started_q     <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      enable_q      <= 1'b0;
      hsync_q       <= ~HS_ON;
      vsync_q       <= ~VS_ON;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      started_q     <= started_d;
      x_q           <= x_d;
      y_q           <= y_d;
      enable_q      <= enable_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign gr_x        = x_q;
  assign gr_y        = y_q;
  assign enable      = enable_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of the raster generator. Instance a uses
// the 800x600 default timing for line-level checks, instance b a 15x8 raster
// for frame-level checks, and instance c a 1x1 raster so that frame_cnt wraps
// within a short run.
module tb_vga_timing_gen;

  logic clk;
  logic reset;
  logic run;

  logic [10:0] a_x, b_x, c_x;
  logic [9:0]  a_y, b_y, c_y;
  logic        a_en, b_en, c_en;
  logic        a_hs, b_hs, c_hs;
  logic        a_vs, b_vs, c_vs;
  logic        a_ls, b_ls, c_ls;
  logic        a_fs, b_fs, c_fs;
  logic [15:0] a_fc, b_fc, c_fc;

  int n_tests;
  int n_fail;

  vga_timing_gen dut_a (
    .clk(clk), .reset(reset), .run(run),
    .gr_x(a_x), .gr_y(a_y), .enable(a_en), .hsync(a_hs), .vsync(a_vs),
    .line_start(a_ls), .frame_start(a_fs), .frame_cnt(a_fc)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) dut_b (
    .clk(clk), .reset(reset), .run(run),
    .gr_x(b_x), .gr_y(b_y), .enable(b_en), .hsync(b_hs), .vsync(b_vs),
    .line_start(b_ls), .frame_start(b_fs), .frame_cnt(b_fc)
  );

  vga_timing_gen #(
    .H_ACTIVE(1), .H_FP(0), .H_SYNC(0), .H_BP(0),
    .V_ACTIVE(1), .V_FP(0), .V_SYNC(0), .V_BP(0)
  ) dut_c (
    .clk(clk), .reset(reset), .run(run),
    .gr_x(c_x), .gr_y(c_y), .enable(c_en), .hsync(c_hs), .vsync(c_vs),
    .line_start(c_ls), .frame_start(c_fs), .frame_cnt(c_fc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance n rising edges and settle just after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int err;
    int xm, ym;
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    run     = 1'b1;

    // Reset held three cycles with run high.
    tick(3);
    check("rst_x", 32'(a_x), 0);
    check("rst_y", 32'(a_y), 0);
    check("rst_en", 32'(a_en), 0);
    check("rst_hs", 32'(a_hs), 0);
    check("rst_vs", 32'(a_vs), 0);
    check("rst_ls", 32'(a_ls), 0);
    check("rst_fs", 32'(a_fs), 0);
    check("rst_fc", 32'(a_fc), 0);

    // First cycle after release presents (0,0).
    reset = 1'b0;
    tick(1);
    check("first_x", 32'(a_x), 0);
    check("first_y", 32'(a_y), 0);
    check("first_en", 32'(a_en), 1);
    check("first_ls", 32'(a_ls), 1);
    check("first_fs", 32'(a_fs), 1);
    check("first_hs", 32'(a_hs), 0);
    check("first_vs", 32'(a_vs), 0);
    check("first_fc", 32'(a_fc), 0);

    // One full default line: enable 0..799, hsync 840..967, period 1056.
    err = 0;
    for (int i = 0; i < 1056; i++) begin
      if (32'(a_x) != 32'(i)) err++;
      if (a_y !== 10'd0) err++;
      if (a_en !== (i < 800)) err++;
      if (a_hs !== (i >= 840 && i < 968)) err++;
      if (a_ls !== (i == 0)) err++;
      if (a_fs !== (i == 0)) err++;
      if (a_vs !== 1'b0) err++;
      if (i == 799) check("en_at_799", 32'(a_en), 1);
      if (i == 800) check("en_at_800", 32'(a_en), 0);
      if (i == 839) check("hs_at_839", 32'(a_hs), 0);
      if (i == 840) check("hs_at_840", 32'(a_hs), 1);
      if (i == 967) check("hs_at_967", 32'(a_hs), 1);
      if (i == 968) check("hs_at_968", 32'(a_hs), 0);
      tick(1);
    end
    check("line_sweep_errs", 32'(err), 0);
    check("line2_x", 32'(a_x), 0);
    check("line2_y", 32'(a_y), 1);
    check("line2_ls", 32'(a_ls), 1);
    check("line2_fs", 32'(a_fs), 0);

    // Freeze at gr_x=839 for 50 cycles, then resume into the sync pulse.
    tick(839);
    check("pre_hold_x", 32'(a_x), 839);
    run = 1'b0;
    tick(50);
    check("hold_x", 32'(a_x), 839);
    check("hold_y", 32'(a_y), 1);
    check("hold_hs", 32'(a_hs), 0);
    check("hold_en", 32'(a_en), 0);
    check("hold_ls", 32'(a_ls), 0);
    run = 1'b1;
    tick(1);
    check("resume_x", 32'(a_x), 840);
    check("resume_hs", 32'(a_hs), 1);

    // Frame timing on the 15x8 raster.
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(1);
    err = 0;
    for (int i = 0; i < 120; i++) begin
      xm = i % 15;
      ym = i / 15;
      if (32'(b_x) != 32'(xm)) err++;
      if (32'(b_y) != 32'(ym)) err++;
      if (b_en !== (xm < 8 && ym < 4)) err++;
      if (b_hs !== (xm >= 10 && xm < 13)) err++;
      if (b_vs !== (ym >= 5 && ym < 7)) err++;
      if (b_ls !== (xm == 0)) err++;
      if (b_fs !== (i == 0)) err++;
      if (b_fc !== 16'd0) err++;
      if (i == 74)  check("vs_at_y4_x14", 32'(b_vs), 0);
      if (i == 75)  check("vs_at_y5_x0", 32'(b_vs), 1);
      if (i == 104) check("vs_at_y6_x14", 32'(b_vs), 1);
      if (i == 105) check("vs_at_y7_x0", 32'(b_vs), 0);
      tick(1);
    end
    check("frame_sweep_errs", 32'(err), 0);
    check("frame2_x", 32'(b_x), 0);
    check("frame2_y", 32'(b_y), 0);
    check("frame2_fs", 32'(b_fs), 1);
    check("frame2_fc", 32'(b_fc), 1);

    // Mid-frame reset inside the vsync pulse aborts the frame.
    tick(80);
    check("pre_rst_y", 32'(b_y), 5);
    check("pre_rst_vs", 32'(b_vs), 1);
    reset = 1'b1;
    tick(1);
    check("midrst_x", 32'(b_x), 0);
    check("midrst_y", 32'(b_y), 0);
    check("midrst_vs", 32'(b_vs), 0);
    check("midrst_hs", 32'(b_hs), 0);
    check("midrst_en", 32'(b_en), 0);
    check("midrst_fs", 32'(b_fs), 0);
    check("midrst_fc", 32'(b_fc), 0);
    reset = 1'b0;
    tick(1);
    check("restart_fs", 32'(b_fs), 1);
    check("restart_en", 32'(b_en), 1);
    check("restart_fc", 32'(b_fc), 0);
    tick(1);
    check("restart_x1", 32'(b_x), 1);

    // frame_cnt wrap on the 1x1 raster, where every cycle starts a frame.
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(1);
    check("c_start_fs", 32'(c_fs), 1);
    check("c_start_fc", 32'(c_fc), 0);
    tick(65535);
    check("c_fc_max", 32'(c_fc), 65535);
    tick(1);
    check("c_fc_wrap", 32'(c_fc), 0);
    check("c_wrap_fs", 32'(c_fs), 1);
    check("c_wrap_x", 32'(c_x), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
